// File: rtl/cselector8_feeder_pkg.sv
// cselector8_feeder_pkg
// Shared definitions for the 8-way selector feeder: FSM state encoding,
// destination mask width and bundle layout helpers.
package cselector8_feeder_pkg;

    localparam int VALID_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETUP     = 2'd1,
        ST_DRIVE     = 2'd2,
        ST_WAIT_FREE = 2'd3
    } state_e;

    // The mask sits directly above the payload in the bundle.
    function automatic int mask_offset(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/cselector8_feeder_fifo.sv
// cselector8_feeder_fifo
// Synchronous FIFO with the head entry always visible (fall-through read).
// Ports:
//   clk, rstn        clock, async active-low reset (flushes pointers/level)
//   push_i, data_i   write request and word; ignored while full
//   pop_i            read request; ignored while empty
//   head_o           oldest entry
//   empty_o, full_o  status from the registered level
//   level_o          occupancy
module cselector8_feeder_fifo
    import cselector8_feeder_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/cselector8_feeder.sv
// cselector8_feeder
// Buffers a valid/ready stream of {mask, payload} words and issues each one
// to the asynchronous 8-way selector as a bundled-data token: bundle first,
// then a drive pulse, then wait for the selector's free event.
// Ports:
//   clk, rstn            clock, async active-low reset
//   i_valid/o_ready      upstream handshake (o_ready = FIFO not full)
//   i_data, i_mask       payload and destination mask
//   o_drive, o_data      drive request and {mask, payload} bundle
//   i_free               free event from the selector, asynchronous to clk
//   o_level              FIFO occupancy
//   o_drop_cnt           zero-mask words discarded, saturating
//   o_err                sticky: free event seen outside WAIT_FREE
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | pop next word; zero mask is dropped, otherwise load bundle
// SETUP     | bundle stable, drive low (setup margin for the selector)
// DRIVE     | drive high for DRIVE_CYCLES cycles
// WAIT_FREE | drive low, bundle held until the free event returns
module cselector8_feeder
    import cselector8_feeder_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int DRIVE_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [DATA_WIDTH-1:0]              i_data,
    input  logic [VALID_BITS-1:0]              i_mask,
    output logic                               o_drive,
    output logic [DATA_WIDTH+VALID_BITS-1:0]   o_data,
    input  logic                               i_free,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_level,
    output logic [7:0]                         o_drop_cnt,
    output logic                               o_err
);

    localparam int BUNDLE_W = DATA_WIDTH + VALID_BITS;
    localparam int MASK_LSB = mask_offset(DATA_WIDTH);
    localparam int LVL_W    = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W    = $clog2(DRIVE_CYCLES + 1);

    logic [BUNDLE_W-1:0]   fifo_head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_pop;
    logic [VALID_BITS-1:0] head_mask;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      drv_cnt_q, drv_cnt_d;
    logic [BUNDLE_W-1:0]   data_q, data_d;
    logic [7:0]            drop_q, drop_d;
    logic                  err_q, err_d;

    logic                  free_tgl_q;
    logic                  free_s1_q, free_s2_q, free_s3_q;
    logic                  free_evt;

    cselector8_feeder_fifo #(
        .WIDTH (BUNDLE_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (i_valid),
        .data_i  ({i_mask, i_data}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (o_level)
    );

    assign head_mask = fifo_head[MASK_LSB +: VALID_BITS];

    // Every i_free rising edge flips the toggle, so pulses shorter than a
    // clk period are still seen; the synchronized toggle change is the event.
    always_ff @(posedge i_free or negedge rstn) begin
        if (!rstn) free_tgl_q <= 1'b0;
        else       free_tgl_q <= ~free_tgl_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            free_s1_q <= 1'b0;
            free_s2_q <= 1'b0;
            free_s3_q <= 1'b0;
        end else begin
            free_s1_q <= free_tgl_q;
            free_s2_q <= free_s1_q;
            free_s3_q <= free_s2_q;
        end
    end

    assign free_evt = free_s2_q ^ free_s3_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            drv_cnt_q <= '0;
            data_q    <= '0;
            drop_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            drv_cnt_q <= drv_cnt_d;
            data_q    <= data_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        drv_cnt_d = drv_cnt_q;
        data_d    = data_q;
        drop_d    = drop_q;
        err_d     = err_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_mask == '0) begin
                        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    end else begin
                        data_d  = fifo_head;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                drv_cnt_d = CNT_W'(DRIVE_CYCLES - 1);
                state_d   = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (drv_cnt_q == '0) state_d = ST_WAIT_FREE;
                else                 drv_cnt_d = drv_cnt_q - CNT_W'(1);
            end
            ST_WAIT_FREE: begin
                if (free_evt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A free event outside WAIT_FREE has no token to retire.
        if (free_evt && (state_q != ST_WAIT_FREE)) err_d = 1'b1;
    end

    // Drive decodes straight from the state flop so reset drops it at once.
    always_comb begin
        o_drive    = (state_q == ST_DRIVE);
        o_ready    = ~fifo_full;
        o_data     = data_q;
        o_drop_cnt = drop_q;
        o_err      = err_q;
    end

endmodule

// File: tb/tb_cselector8_feeder.sv
module tb_cselector8_feeder;
    import cselector8_feeder_pkg::*;

    localparam int DW = 32;
    localparam int DC = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic [7:0]    i_mask;
    logic          o_drive;
    logic [DW+7:0] o_data;
    logic          i_free;
    logic [2:0]    o_level;
    logic [7:0]    o_drop_cnt;
    logic          o_err;

    int            assertions = 0;
    int            failures = 0;
    logic [DW+7:0] sb_q[$];
    int            drive_count = 0;
    int            free_evt_count = 0;
    int            hi_cnt = 0;
    bit            drive_prev = 0;
    int            exp_drop = 0;

    cselector8_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .DRIVE_CYCLES(DC)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_mask     (i_mask),
        .o_drive    (o_drive),
        .o_data     (o_data),
        .i_free     (i_free),
        .o_level    (o_level),
        .o_drop_cnt (o_drop_cnt),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    // Token monitor: each drive rising edge retires the oldest expected bundle,
    // each falling edge checks the pulse width.
    always @(negedge clk) begin
        logic [DW+7:0] exp;
        if (!rstn) begin
            drive_prev = 0;
            hi_cnt = 0;
        end else begin
            if (dut.free_evt) free_evt_count++;
            if (o_drive) begin
                if (!drive_prev) begin
                    drive_count++;
                    assertions++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL token_data: unexpected drive, o_data=%h, no token expected", o_data);
                    end else begin
                        exp = sb_q.pop_front();
                        if (o_data !== exp) begin
                            failures++;
                            $display("FAIL token_data: o_data=%h expected %h", o_data, exp);
                        end
                    end
                end
                hi_cnt++;
            end else if (drive_prev) begin
                assertions++;
                if (hi_cnt != DC) begin
                    failures++;
                    $display("FAIL drive_width: high for %0d cycles expected %0d", hi_cnt, DC);
                end
                hi_cnt = 0;
            end
            drive_prev = o_drive;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic [7:0] m, output bit ok);
        ok = 0;
        i_valid = 1; i_data = d; i_mask = m;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_ready) begin
                if (m != 8'h00) sb_q.push_back({m, d});
                tick();
                ok = 1;
                break;
            end
            tick();
        end
        i_valid = 0;
    endtask

    task automatic wait_state(input state_e st, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            if (dut.state_q == st) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic free_pulse(input int w);
        i_free = 1;
        #(w);
        i_free = 0;
    endtask

    task automatic test_reset();
        rstn = 0; i_valid = 0; i_data = '0; i_mask = '0; i_free = 0;
        repeat (3) tick();
        rstn = 1;
        tick();
        assertions++; if (o_drive !== 1'b0)    begin failures++; $display("FAIL reset_drive: got %b want 0", o_drive); end
        assertions++; if (o_data !== '0)       begin failures++; $display("FAIL reset_data: got %h want 0", o_data); end
        assertions++; if (o_level !== 3'd0)    begin failures++; $display("FAIL reset_level: got %0d want 0", o_level); end
        assertions++; if (o_ready !== 1'b1)    begin failures++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        assertions++; if (o_drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop: got %0d want 0", o_drop_cnt); end
        assertions++; if (o_err !== 1'b0)      begin failures++; $display("FAIL reset_err: got %b want 0", o_err); end
    endtask

    task automatic test_single();
        i_valid = 1; i_data = 32'hDEADBEEF; i_mask = 8'h04;
        sb_q.push_back({8'h04, 32'hDEADBEEF});
        tick();                                   // edge k: accepted
        i_valid = 0;
        assertions++; if (o_level !== 3'd1) begin failures++; $display("FAIL single_level: got %0d want 1", o_level); end
        tick();                                   // k+1
        assertions++; if (o_data !== 40'h04DEADBEEF) begin failures++; $display("FAIL single_data: got %h want 04deadbeef", o_data); end
        assertions++; if (o_drive !== 1'b0) begin failures++; $display("FAIL single_setup_drive: got %b want 0", o_drive); end
        tick();                                   // k+2
        assertions++; if (o_drive !== 1'b1) begin failures++; $display("FAIL single_drive_k2: got %b want 1", o_drive); end
        tick();                                   // k+3
        assertions++; if (o_drive !== 1'b1) begin failures++; $display("FAIL single_drive_k3: got %b want 1", o_drive); end
        tick();                                   // k+4
        assertions++; if (o_drive !== 1'b0) begin failures++; $display("FAIL single_drive_k4: got %b want 0", o_drive); end
        assertions++; if (dut.state_q !== ST_WAIT_FREE) begin failures++; $display("FAIL single_wait: state %0d want 3", dut.state_q); end
        i_free = 1;                               // rising edge just after edge E
        tick(); tick();                           // E+2
        i_free = 0;
        assertions++; if (dut.state_q !== ST_WAIT_FREE) begin failures++; $display("FAIL single_free_early: state %0d want 3", dut.state_q); end
        tick();                                   // E+3
        assertions++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL single_free_idle: state %0d want 0", dut.state_q); end
        assertions++; if (o_data !== 40'h04DEADBEEF) begin failures++; $display("FAIL single_hold: got %h want 04deadbeef", o_data); end
    endtask

    task automatic test_burst();
        logic [7:0] masks [6] = '{8'h01, 8'h02, 8'h0C, 8'hFF, 8'h80, 8'h41};
        int n = 0;
        bit ok;
        for (int c = 0; c < 20; c++) begin
            i_valid = 1; i_data = 32'h1000_0000 + n * 32'h1111; i_mask = masks[n];
            @(negedge clk);
            if (!o_ready) break;
            sb_q.push_back({i_mask, i_data});
            n++;
            tick();
            if (n == 6) break;
        end
        assertions++; if (n != 5) begin failures++; $display("FAIL burst_accepts: got %0d want 5", n); end
        assertions++; if (o_level !== 3'd4) begin failures++; $display("FAIL burst_level: got %0d want 4", o_level); end
        tick();
        i_valid = 0;
        for (int t = 0; t < 5; t++) begin
            wait_state(ST_WAIT_FREE, 40, ok);
            assertions++; if (!ok) begin failures++; $display("FAIL burst_wait_free: token %0d timeout", t); end
            free_pulse(3);
            wait_state(ST_IDLE, 10, ok);
            assertions++; if (!ok) begin failures++; $display("FAIL burst_idle: token %0d timeout", t); end
        end
        assertions++; if (o_level !== 3'd0) begin failures++; $display("FAIL burst_drain_level: got %0d want 0", o_level); end
        assertions++; if (sb_q.size() != 0) begin failures++; $display("FAIL burst_drain: %0d tokens not issued, want 0", sb_q.size()); end
    endtask

    task automatic test_drop();
        int d0 = drive_count;
        bit ok;
        push_word(32'hAAAA_0001, 8'h10, ok);
        push_word(32'hBAD0_0000, 8'h00, ok);
        push_word(32'hAAAA_0002, 8'h81, ok);
        exp_drop++;
        for (int t = 0; t < 2; t++) begin
            wait_state(ST_WAIT_FREE, 40, ok);
            assertions++; if (!ok) begin failures++; $display("FAIL drop_wait_free: token %0d timeout", t); end
            free_pulse(3);
            wait_state(ST_IDLE, 10, ok);
        end
        repeat (4) tick();
        assertions++; if (o_drop_cnt !== 8'(exp_drop)) begin failures++; $display("FAIL drop_cnt: got %0d want %0d", o_drop_cnt, exp_drop); end
        assertions++; if (drive_count - d0 != 2) begin failures++; $display("FAIL drop_drives: got %0d want 2", drive_count - d0); end
    endtask

    task automatic test_short_free();
        int c0;
        bit ok;
        push_word(32'h5151_5151, 8'h22, ok);
        wait_state(ST_WAIT_FREE, 40, ok);
        assertions++; if (!ok) begin failures++; $display("FAIL short_wait_free: timeout"); end
        c0 = free_evt_count;
        free_pulse(1);
        wait_state(ST_IDLE, 10, ok);
        assertions++; if (!ok) begin failures++; $display("FAIL short_free_advance: no return to IDLE"); end
        repeat (4) tick();
        assertions++; if (free_evt_count - c0 != 1) begin failures++; $display("FAIL short_free_evt: got %0d events want 1", free_evt_count - c0); end
        assertions++; if (o_err !== 1'b0) begin failures++; $display("FAIL short_free_err: got %b want 0", o_err); end
    endtask

    task automatic test_free_in_drive();
        bit ok;
        push_word(32'h7777_0000, 8'h08, ok);
        wait_state(ST_SETUP, 10, ok);
        // Issued in SETUP, the synchronized event lands while DRIVE is active.
        free_pulse(3);
        wait_state(ST_WAIT_FREE, 20, ok);
        assertions++; if (!ok) begin failures++; $display("FAIL err_wait_free: timeout"); end
        repeat (8) tick();
        assertions++; if (o_err !== 1'b1) begin failures++; $display("FAIL err_flag: got %b want 1", o_err); end
        assertions++; if (dut.state_q !== ST_WAIT_FREE) begin failures++; $display("FAIL err_still_waiting: state %0d want 3", dut.state_q); end
        free_pulse(3);
        wait_state(ST_IDLE, 10, ok);
        assertions++; if (!ok) begin failures++; $display("FAIL err_release: no return to IDLE"); end
    endtask

    task automatic test_drop_saturate();
        bit ok;
        for (int i = 0; i < 260; i++) push_word(32'(i), 8'h00, ok);
        exp_drop = (exp_drop + 260 > 255) ? 255 : exp_drop + 260;
        repeat (3) tick();
        assertions++; if (o_drop_cnt !== 8'(exp_drop)) begin failures++; $display("FAIL drop_saturate: got %0d want %0d", o_drop_cnt, exp_drop); end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit ok;
        for (int i = 0; i < 4; i++) push_word(32'hC0DE_0000 + 32'(i), 8'h01 << i, ok);
        wait_state(ST_DRIVE, 20, ok);
        assertions++; if (!ok) begin failures++; $display("FAIL rmid_reach_drive: timeout"); end
        #2 rstn = 0;
        #1;
        sb_q.delete();
        exp_drop = 0;
        assertions++; if (o_drive !== 1'b0) begin failures++; $display("FAIL rmid_drive: got %b want 0", o_drive); end
        assertions++; if (o_level !== 3'd0) begin failures++; $display("FAIL rmid_level: got %0d want 0", o_level); end
        assertions++; if (o_data !== '0)    begin failures++; $display("FAIL rmid_data: got %h want 0", o_data); end
        assertions++; if (o_err !== 1'b0)   begin failures++; $display("FAIL rmid_err: got %b want 0", o_err); end
        assertions++; if (o_drop_cnt !== 8'd0) begin failures++; $display("FAIL rmid_drop: got %0d want 0", o_drop_cnt); end
        tick(); tick();
        rstn = 1;
        d0 = drive_count;
        repeat (10) tick();
        assertions++; if (drive_count != d0) begin failures++; $display("FAIL rmid_no_drive: got %0d drives want 0", drive_count - d0); end
        push_word(32'h0BAD_F00D, 8'h20, ok);
        wait_state(ST_WAIT_FREE, 20, ok);
        free_pulse(3);
        wait_state(ST_IDLE, 10, ok);
        assertions++; if (drive_count - d0 != 1) begin failures++; $display("FAIL rmid_recover: got %0d drives want 1", drive_count - d0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_drop();
        test_short_free();
        test_free_in_drive();
        test_drop_saturate();
        test_reset_mid();
        repeat (3) tick();
        assertions++; if (sb_q.size() != 0) begin failures++; $display("FAIL final_scoreboard: %0d tokens outstanding want 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cselector8_feeder.md
# cselector8_feeder

Clocked source stage directly upstream of the 8-way click-pipeline selector. Accepts a valid/ready stream of data words with an 8-bit destination mask, buffers them in a small FIFO, and issues each word as a bundled-data token: a stable data+mask bundle, then a drive pulse. It issues the next token only after the selector's free event returns. It bridges the synchronous datapath into the asynchronous selector network.

## Interface
- DATA_WIDTH, 32: payload width; bundle width is DATA_WIDTH+8.
- FIFO_DEPTH, 4: input buffer entries; power of two, ≥2.
- DRIVE_CYCLES, 2: o_drive high time in clk cycles; ≥1.

Ports:
- clk  in  1  single clock; all state except the free-capture flop.
- rstn  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  FIFO not full; a transfer occurs when i_valid & o_ready at posedge clk.
- i_data  in  DATA_WIDTH  payload.
- i_mask  in  8  destination valid bits; multiple bits set = multicast.
- o_drive  out  1  drive request to the selector.
- o_data  out  DATA_WIDTH+8  bundle: {mask[7:0], payload}; mask occupies the top 8 bits.
- i_free  in  1  free event from the selector; asynchronous to clk.
- o_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- o_drop_cnt  out  8  count of zero-mask words discarded; saturates at 255.
- o_err  out  1  sticky flag: free event received outside WAIT_FREE.

## Operation
- FIFO: synchronous, first-word fall-through internally.
  - Push on i_valid & o_ready.
  - Pop only by the FSM in IDLE.
  - o_ready = ~full, registered-full based; push is never accepted at full, even with a same-cycle pop.
- Free capture:
  - A toggle flop clocked on posedge i_free, async-reset by rstn.
  - Followed by a 2-FF synchronizer and an edge compare.
  - Yields a 1-cycle free_evt per i_free rising edge, regardless of i_free pulse width.
- FSM states: IDLE, SETUP, DRIVE, WAIT_FREE.
  - IDLE: if FIFO non-empty, pop. If the popped mask is 0, increment o_drop_cnt and stay in IDLE; otherwise load o_data and go to SETUP.
  - SETUP: one cycle of o_data stable with o_drive low (bundled-data setup margin). Go to DRIVE.
  - DRIVE: o_drive=1 for DRIVE_CYCLES cycles, counted by a drive counter. Then go to WAIT_FREE.
  - WAIT_FREE: o_drive=0, o_data held. On free_evt go to IDLE.
- o_data changes only on an IDLE pop; it holds between tokens.
- free_evt in IDLE, SETUP or DRIVE: ignored for sequencing; sets o_err (cleared only by reset).

## Timing
- Reset values: o_drive=0, o_data=0, o_level=0, o_ready=1, o_drop_cnt=0, o_err=0, FSM=IDLE, toggle/sync flops=0.
- Reset mid-operation: token abandoned, FIFO flushed, o_drive drops asynchronously.
- Word accepted at edge k into an empty FIFO with idle FSM:
  - o_data valid after edge k+1.
  - o_drive high from edge k+2 through edge k+2+DRIVE_CYCLES.
- free_evt asserts 3 clk edges after the i_free rising edge (toggle, sync1, sync2/compare).
- WAIT_FREE→IDLE on the free_evt edge. The next pop is the following edge, so the minimum token period is DRIVE_CYCLES+2+free round trip+1 cycles.
- Zero-mask drop: one cycle per word, no drive.
- o_level updates the cycle after push/pop. A simultaneous push and pop (not full) leaves o_level unchanged.
- o_drop_cnt holds at 255.

## Structure
- Shared package holds:
  - FSM state encoding (2 bits: IDLE=0, SETUP=1, DRIVE=2, WAIT_FREE=3).
  - VALID_BITS=8.
  - Bundle layout constants: mask offset = DATA_WIDTH.
- Sub-module cselector8_feeder_fifo: parameterized sync FIFO (DATA_WIDTH+8 wide), outputs head, empty, full, level.
- Free toggle-synchronizer stays inline.

## Test plan
- Single word 0xDEADBEEF, mask 0x04 into an idle block:
  - o_data=0x04_DEADBEEF at k+1.
  - o_drive high for 2 cycles from k+2.
  - Pulse i_free → state IDLE 3 cycles later.
- Burst of 6 words with i_free withheld:
  - o_ready falls after 5 accepts (4 in FIFO + 1 in flight); o_level=4.
  - Releasing 5 free pulses drains all words in order.
- Zero-mask word between two valid words:
  - o_drop_cnt=1.
  - Only 2 drive pulses, carrying mask bits of the valid words.
- i_free pulse of 1 ns (shorter than clk period) during WAIT_FREE: still produces exactly one free_evt; FSM advances.
- i_free pulse during DRIVE: o_err=1; FSM still waits in WAIT_FREE for the next free.
- rstn asserted during DRIVE with 3 words queued: o_drive=0 immediately, o_level=0, o_data=0; after release, no drive until a new push.
